// File: rtl/mem_stage_pkg.sv
// Shared definitions for the RV32I memory stage: aluop constants, FSM states,
// load/store decode and load-data extension.
package mem_stage_pkg;

  localparam int ALU_OP_BUS_W = 8;
  typedef logic [ALU_OP_BUS_W-1:0] alu_op_t;

  localparam alu_op_t EX_NOP = 8'h00;
  localparam alu_op_t EX_ADD = 8'h01;
  localparam alu_op_t EX_LB  = 8'h20;
  localparam alu_op_t EX_LH  = 8'h21;
  localparam alu_op_t EX_LW  = 8'h22;
  localparam alu_op_t EX_LBU = 8'h24;
  localparam alu_op_t EX_LHU = 8'h25;
  localparam alu_op_t EX_SB  = 8'h28;
  localparam alu_op_t EX_SH  = 8'h29;
  localparam alu_op_t EX_SW  = 8'h2a;

  typedef enum logic [1:0] {ST_IDLE, ST_ACCESS, ST_DRAIN, ST_DONE} mem_state_e;

  // last = index of the final byte (n-1)
  typedef struct packed {
    logic       is_mem;
    logic       is_load;
    logic       sgn;
    logic [1:0] last;
  } mem_dec_t;

  function automatic mem_dec_t decode(alu_op_t op);
    mem_dec_t d;
    d = '0;
    case (op)
      EX_LB:  d = '{is_mem: 1'b1, is_load: 1'b1, sgn: 1'b1, last: 2'd0};
      EX_LH:  d = '{is_mem: 1'b1, is_load: 1'b1, sgn: 1'b1, last: 2'd1};
      EX_LW:  d = '{is_mem: 1'b1, is_load: 1'b1, sgn: 1'b0, last: 2'd3};
      EX_LBU: d = '{is_mem: 1'b1, is_load: 1'b1, sgn: 1'b0, last: 2'd0};
      EX_LHU: d = '{is_mem: 1'b1, is_load: 1'b1, sgn: 1'b0, last: 2'd1};
      EX_SB:  d = '{is_mem: 1'b1, is_load: 1'b0, sgn: 1'b0, last: 2'd0};
      EX_SH:  d = '{is_mem: 1'b1, is_load: 1'b0, sgn: 1'b0, last: 2'd1};
      EX_SW:  d = '{is_mem: 1'b1, is_load: 1'b0, sgn: 1'b0, last: 2'd3};
      default: d = '0;
    endcase
    return d;
  endfunction

  function automatic logic [31:0] load_ext(logic [31:0] r, logic [1:0] last, logic sgn);
    logic [31:0] v;
    case (last)
      2'd0:    v = {{24{sgn & r[7]}}, r[7:0]};
      2'd1:    v = {{16{sgn & r[15]}}, r[15:0]};
      default: v = r;
    endcase
    return v;
  endfunction

endpackage

// File: rtl/mem_stage_if.sv
// Byte-wide RAM port shared with instruction fetch through the memory arbiter.
interface mem_stage_if #(parameter int ADDR_W = 32);
  logic              req;
  logic              wr;
  logic [ADDR_W-1:0] addr;
  logic [7:0]        dout;
  logic              gnt;
  logic [7:0]        din;

  modport master (output req, wr, addr, dout, input gnt, din);
  modport slave  (input req, wr, addr, dout, output gnt, din);
endinterface

// File: rtl/mem_byte_seq.sv
// Byte sequencer for the memory stage: FSM, byte counter, req/gnt handling
// and the load assembly register.
module mem_byte_seq
  import mem_stage_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_op,
  input  logic        is_load,
  input  logic        misalign,
  input  logic [1:0]  last,
  input  logic        gnt,
  input  logic [7:0]  din,
  output logic        req,
  output logic [1:0]  idx,
  output logic        stall,
  output logic        done,
  output logic [31:0] rdata
);

  mem_state_e state, state_nx;
  logic [1:0] cnt, cnt_nx;
  logic       rd_pend;
  logic [1:0] rd_idx;

  // The op's first (IDLE) cycle already issues byte 0, so an uncontended
  // access of n bytes holds the pipeline for n cycles (plus DRAIN for loads).
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    req      = 1'b0;
    stall    = 1'b0;
    case (state)
      ST_IDLE: if (mem_op) begin
        stall = 1'b1;
        if (misalign) state_nx = ST_DONE;
        else begin
          req      = 1'b1;
          state_nx = ST_ACCESS;
        end
      end
      ST_ACCESS: begin
        stall = 1'b1;
        req   = 1'b1;
      end
      ST_DRAIN: begin
        stall    = 1'b1;
        state_nx = ST_DONE;
      end
      ST_DONE: state_nx = ST_IDLE;
      default: state_nx = ST_IDLE;
    endcase
    if (req && gnt) begin
      if (cnt == last) begin
        state_nx = is_load ? ST_DRAIN : ST_DONE;
        cnt_nx   = 2'd0;
      end else begin
        state_nx = ST_ACCESS;
        cnt_nx   = cnt + 2'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= ST_IDLE;
      cnt     <= 2'd0;
      rd_pend <= 1'b0;
      rd_idx  <= 2'd0;
      rdata   <= '0;
    end else begin
      state   <= state_nx;
      cnt     <= cnt_nx;
      rd_pend <= req && gnt && is_load;
      rd_idx  <= cnt;
      // read byte arrives the cycle after its grant
      if (rd_pend) rdata[{rd_idx, 3'b000} +: 8] <= din;
    end
  end

  assign idx  = cnt;
  assign done = (state == ST_DONE);

endmodule

// File: rtl/mem_stage.sv
// RV32I memory stage: ALU pass-through, byte-serial loads/stores on the shared RAM port.
// Optional MEM_ALIGN_CHECK_EN: misaligned halfword/word accesses complete without RAM access.
module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int OP_W   = ALU_OP_BUS_W
)(
  input  logic              clk,
  input  logic              rst,
  input  logic [OP_W-1:0]   aluop_i,
  input  logic [4:0]        wd_i,
  input  logic              wreg_i,
  input  logic [31:0]       wdata_i,
  input  logic [ADDR_W-1:0] memd_i,
  mem_stage_if.master       mem,
  output logic [4:0]        wd_o,
  output logic              wreg_o,
  output logic [31:0]       wdata_o,
  output logic              stall_req
);

  mem_dec_t    dec;
  logic        misalign;
  logic        req, stall, done;
  logic [1:0]  idx;
  logic [31:0] rdata;

  assign dec = decode(alu_op_t'(aluop_i));

`ifdef MEM_ALIGN_CHECK_EN
  assign misalign = dec.is_mem &&
                    (((dec.last == 2'd1) && memd_i[0]) ||
                     ((dec.last == 2'd3) && (memd_i[1:0] != 2'b00)));
`else
  assign misalign = 1'b0;
`endif

  mem_byte_seq u_seq (
    .clk      (clk),
    .rst      (rst),
    .mem_op   (dec.is_mem),
    .is_load  (dec.is_load),
    .misalign (misalign),
    .last     (dec.last),
    .gnt      (mem.gnt),
    .din      (mem.din),
    .req      (req),
    .idx      (idx),
    .stall    (stall),
    .done     (done),
    .rdata    (rdata)
  );

  // Outputs are gated by reset so an abort drops req/wr in the same instant.
  always_comb begin
    mem.req   = 1'b0;
    mem.wr    = 1'b0;
    mem.addr  = '0;
    mem.dout  = '0;
    wd_o      = '0;
    wreg_o    = 1'b0;
    wdata_o   = '0;
    stall_req = 1'b0;
    if (rst) begin
      stall_req = stall;
      if (req) begin
        mem.req  = 1'b1;
        mem.wr   = ~dec.is_load;
        mem.addr = memd_i + ADDR_W'(idx);
        mem.dout = wdata_i[{idx, 3'b000} +: 8];
      end
      wd_o = wd_i;
      if (!dec.is_mem) begin
        wreg_o  = wreg_i;
        wdata_o = wdata_i;
      end else if (done && !misalign && dec.is_load) begin
        wreg_o  = wreg_i;
        wdata_o = load_ext(rdata, dec.last, dec.sgn);
      end
      if (wd_i == 5'd0) wreg_o = 1'b0;
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage with a byte-wide RAM model on the slave side.
module tb_mem_stage;
  import mem_stage_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  aluop;
  logic [4:0]  wd_i;
  logic        wreg_i;
  logic [31:0] wdata_i, memd_i;
  logic [4:0]  wd_o;
  logic        wreg_o;
  logic [31:0] wdata_o;
  logic        stall_req;

  mem_stage_if #(.ADDR_W(32)) mbus ();

  logic [7:0]  ram [0:4095];
  int          total = 0, bad = 0;
  int          r_stall, r_req;
  logic        r_done, r_wreg;
  logic [31:0] r_wdata;
  logic [31:0] r_addr [0:19];

  mem_stage dut (
    .clk(clk), .rst(rst), .aluop_i(aluop), .wd_i(wd_i), .wreg_i(wreg_i),
    .wdata_i(wdata_i), .memd_i(memd_i), .mem(mbus),
    .wd_o(wd_o), .wreg_o(wreg_o), .wdata_o(wdata_o), .stall_req(stall_req)
  );

  always #5 clk = ~clk;

  always @(posedge clk)
    if (rst && mbus.req && mbus.gnt) begin
      if (mbus.wr) ram[mbus.addr[11:0]] <= mbus.dout;
      else         mbus.din <= ram[mbus.addr[11:0]];
    end

  // Entered and left at posedge+1; gpat bit c is the grant for op cycle c.
  task automatic run_op(input string name, input logic [7:0] op, input logic [31:0] addr,
                        input logic [31:0] data, input logic [4:0] wd, input logic we,
                        input logic [31:0] gpat);
    aluop = op; memd_i = addr; wdata_i = data; wd_i = wd; wreg_i = we;
    r_stall = 0; r_req = 0; r_done = 1'b0; r_wreg = 1'bx; r_wdata = 'x;
    for (int c = 0; c < 20; c++) begin
      mbus.gnt = gpat[c];
      @(negedge clk);
      r_addr[c] = mbus.addr;
      if (mbus.req) r_req++;
      if (!stall_req) begin
        r_done = 1'b1; r_wdata = wdata_o; r_wreg = wreg_o;
        @(posedge clk); #1;
        break;
      end
      r_stall++;
      @(posedge clk); #1;
    end
    aluop = EX_NOP; mbus.gnt = 1'b0;
    total++;
    if (!r_done) begin bad++; $display("FAIL %s timeout: no DONE within 20 cycles", name); end
  endtask

  task automatic test_reset;
    rst = 1'b0; aluop = EX_ADD; wdata_i = 32'h1234_5678; wd_i = 5'd5; wreg_i = 1'b1;
    memd_i = 32'h0; mbus.gnt = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    total++; if (wdata_o !== 32'h0) begin bad++; $display("FAIL reset_wdata got=%h exp=0", wdata_o); end
    total++; if ({wreg_o, wd_o, stall_req, mbus.req, mbus.wr} !== 9'b0)
      begin bad++; $display("FAIL reset_ctl got=%b exp=0", {wreg_o, wd_o, stall_req, mbus.req, mbus.wr}); end
    rst = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_passthrough;
    aluop = EX_ADD; wdata_i = 32'h1234_5678; wd_i = 5'd5; wreg_i = 1'b1; memd_i = 32'h100;
    #1;
    total++; if (wdata_o !== 32'h1234_5678) begin bad++; $display("FAIL add_wdata got=%h exp=12345678", wdata_o); end
    total++; if ({wd_o, wreg_o, stall_req, mbus.req} !== {5'd5, 1'b1, 1'b0, 1'b0})
      begin bad++; $display("FAIL add_ctl got=%b exp=%b", {wd_o, wreg_o, stall_req, mbus.req}, {5'd5, 3'b100}); end
    wd_i = 5'd0;
    #1;
    total++; if (wreg_o !== 1'b0) begin bad++; $display("FAIL add_wd0_wreg got=%b exp=0", wreg_o); end
    @(posedge clk); #1;
  endtask

  task automatic test_store;
    run_op("sw", EX_SW, 32'h100, 32'hDEAD_BEEF, 5'd3, 1'b1, 32'hFFFF_FFFF);
    total++; if (r_stall !== 4) begin bad++; $display("FAIL sw_stall got=%0d exp=4", r_stall); end
    total++; if (r_wreg !== 1'b0) begin bad++; $display("FAIL sw_wreg got=%b exp=0", r_wreg); end
    total++; if ({ram[12'h103], ram[12'h102], ram[12'h101], ram[12'h100]} !== 32'hDEAD_BEEF)
      begin bad++; $display("FAIL sw_ram got=%h exp=deadbeef", {ram[12'h103], ram[12'h102], ram[12'h101], ram[12'h100]}); end
    total++; if ({r_addr[0][11:0], r_addr[3][11:0]} !== {12'h100, 12'h103})
      begin bad++; $display("FAIL sw_addr got=%h,%h exp=100,103", r_addr[0], r_addr[3]); end
    run_op("sw104", EX_SW, 32'h104, 32'h0000_6655, 5'd3, 1'b1, 32'hFFFF_FFFF);
    run_op("sw300", EX_SW, 32'h300, 32'h4433_2211, 5'd3, 1'b1, 32'hFFFF_FFFF);
    run_op("sb", EX_SB, 32'h200, 32'hFFFF_FF80, 5'd3, 1'b1, 32'hFFFF_FFFF);
    total++; if (r_stall !== 1 || ram[12'h200] !== 8'h80)
      begin bad++; $display("FAIL sb got stall=%0d byte=%h exp stall=1 byte=80", r_stall, ram[12'h200]); end
  endtask

  task automatic test_load_byte;
    run_op("lb", EX_LB, 32'h200, 32'h0, 5'd7, 1'b1, 32'hFFFF_FFFF);
    total++; if (r_wdata !== 32'hFFFF_FF80) begin bad++; $display("FAIL lb_wdata got=%h exp=ffffff80", r_wdata); end
    total++; if (r_stall !== 2 || r_wreg !== 1'b1)
      begin bad++; $display("FAIL lb_ctl got stall=%0d wreg=%b exp stall=2 wreg=1", r_stall, r_wreg); end
    run_op("lbu", EX_LBU, 32'h200, 32'h0, 5'd7, 1'b1, 32'hFFFF_FFFF);
    total++; if (r_wdata !== 32'h0000_0080 || r_stall !== 2)
      begin bad++; $display("FAIL lbu got wdata=%h stall=%0d exp 00000080/2", r_wdata, r_stall); end
  endtask

  task automatic test_load_gaps;
    run_op("lw_gap", EX_LW, 32'h300, 32'h0, 5'd8, 1'b1, 32'hFFFF_FFF3);
    total++; if (r_wdata !== 32'h4433_2211) begin bad++; $display("FAIL lw_gap_wdata got=%h exp=44332211", r_wdata); end
    total++; if (r_stall !== 7) begin bad++; $display("FAIL lw_gap_stall got=%0d exp=7", r_stall); end
    total++; if ({r_addr[1][11:0], r_addr[2][11:0], r_addr[3][11:0], r_addr[4][11:0], r_addr[5][11:0]}
                 !== {12'h301, 12'h302, 12'h302, 12'h302, 12'h303})
      begin bad++; $display("FAIL lw_gap_addr got=%h %h %h %h %h exp=301 302 302 302 303",
                            r_addr[1], r_addr[2], r_addr[3], r_addr[4], r_addr[5]); end
  endtask

  task automatic test_back_to_back;
    run_op("sh", EX_SH, 32'h210, 32'h0000_8765, 5'd2, 1'b1, 32'hFFFF_FFFF);
    run_op("lh", EX_LH, 32'h210, 32'h0, 5'd2, 1'b1, 32'hFFFF_FFFF);
    total++; if (r_wdata !== 32'hFFFF_8765 || r_stall !== 3)
      begin bad++; $display("FAIL lh got wdata=%h stall=%0d exp ffff8765/3", r_wdata, r_stall); end
    run_op("lhu", EX_LHU, 32'h210, 32'h0, 5'd0, 1'b1, 32'hFFFF_FFFF);
    total++; if (r_wdata !== 32'h0000_8765 || r_wreg !== 1'b0)
      begin bad++; $display("FAIL lhu_wd0 got wdata=%h wreg=%b exp 00008765/0", r_wdata, r_wreg); end
  endtask

  task automatic test_misalign;
    run_op("lw_mis", EX_LW, 32'h102, 32'h0, 5'd9, 1'b1, 32'hFFFF_FFFF);
`ifdef MEM_ALIGN_CHECK_EN
    total++; if (r_stall !== 1 || r_req !== 0)
      begin bad++; $display("FAIL lw_mis got stall=%0d req=%0d exp 1/0", r_stall, r_req); end
    total++; if (r_wreg !== 1'b0 || r_wdata !== 32'h0)
      begin bad++; $display("FAIL lw_mis_out got wreg=%b wdata=%h exp 0/0", r_wreg, r_wdata); end
`else
    total++; if (r_stall !== 5 || r_req !== 4)
      begin bad++; $display("FAIL lw_mis got stall=%0d req=%0d exp 5/4", r_stall, r_req); end
    total++; if (r_wreg !== 1'b1 || r_wdata !== 32'h6655_DEAD)
      begin bad++; $display("FAIL lw_mis_out got wreg=%b wdata=%h exp 1/6655dead", r_wreg, r_wdata); end
`endif
  endtask

  task automatic test_reset_abort;
    run_op("sw_clr", EX_SW, 32'h180, 32'h0, 5'd1, 1'b0, 32'hFFFF_FFFF);
    aluop = EX_SW; memd_i = 32'h180; wdata_i = 32'hA1B2_C3D4; mbus.gnt = 1'b1;
    repeat (2) begin @(posedge clk); #1; end
    total++; if (mbus.req !== 1'b1 || mbus.addr !== 32'h182)
      begin bad++; $display("FAIL abort_pre got req=%b addr=%h exp 1/182", mbus.req, mbus.addr); end
    rst = 1'b0;
    #1;
    total++; if ({mbus.req, mbus.wr, stall_req} !== 3'b000 || dut.u_seq.state !== ST_IDLE)
      begin bad++; $display("FAIL abort got req/wr/stall=%b state=%0d exp 000/IDLE",
                            {mbus.req, mbus.wr, stall_req}, dut.u_seq.state); end
    aluop = EX_ADD; wdata_i = 32'h0BAD_F00D; wd_i = 5'd4; wreg_i = 1'b1; mbus.gnt = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    total++; if ({ram[12'h183], ram[12'h182], ram[12'h181], ram[12'h180]} !== 32'h0000_C3D4)
      begin bad++; $display("FAIL abort_ram got=%h exp=0000c3d4", {ram[12'h183], ram[12'h182], ram[12'h181], ram[12'h180]}); end
    total++; if (wdata_o !== 32'h0BAD_F00D || {wreg_o, stall_req, mbus.req} !== 3'b100)
      begin bad++; $display("FAIL abort_add got wdata=%h ctl=%b exp 0badf00d/100", wdata_o, {wreg_o, stall_req, mbus.req}); end
  endtask

  initial begin
    test_reset();
    test_passthrough();
    test_store();
    test_load_byte();
    test_load_gaps();
    test_back_to_back();
    test_misalign();
    test_reset_abort();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
